// File: rtl/cpu_pkg.sv
// Shared core types: hazard sequencer states and the pipeline control bundle
// distributed to the pipeline registers.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        FLUSH,
        MEM_WAIT
    } hazard_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic inhibit_control;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/perf_counter.sv
// 32-bit wrapping event counter with increment enable.
module perf_counter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= 32'd0;
        end else if (inc_i) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: post-reset bubbles, load-use stalls, taken-branch flushes
// and data-memory wait states, plus a sticky memory-timeout flag and perf counters.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned RESET_BUBBLES = 2,
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned MEM_TIMEOUT   = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ready_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        id_ex_stall_o,
    output logic        ex_mem_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        inhibit_control_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    localparam int unsigned       WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [3:0]        BUBBLE_INIT = 4'(RESET_BUBBLES - 1);
    localparam logic [3:0]        FLUSH_INIT  = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [WAIT_W-1:0] WAIT_MAX    = WAIT_W'(MEM_TIMEOUT);

    hazard_state_t     state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    pipe_ctrl_t        ctrl;
    logic              flush_evt;
    logic              mem_wait;
    logic              load_use;

    assign mem_wait = mem_req_i & ~mem_ready_i;
    assign load_use = ex_mem_read_i && (ex_rd_i != REG_ZERO) &&
                      ((id_uses_rs1_i && (ex_rd_i == id_rs1_i)) ||
                       (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

    always_comb begin
        ctrl      = '0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        flush_evt = 1'b0;

        if (state_q == BOOT) begin
            ctrl.if_id_flush     = 1'b1;
            ctrl.id_ex_flush     = 1'b1;
            ctrl.inhibit_control = 1'b1;
            if (cnt_q == 4'd0) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if ((state_q == MEM_WAIT) ? !mem_ready_i : mem_wait) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            if (state_q == MEM_WAIT) begin
                if (wait_q != WAIT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end else begin
                // Entering from RUN or FLUSH; any remaining flush cycles are dropped.
                state_d = MEM_WAIT;
                wait_d  = WAIT_W'(1);
            end
        end else begin
            // RUN rules, also applied on the cycle a memory wait completes.
            if (state_q == MEM_WAIT) begin
                state_d = RUN;
            end
            if (ex_branch_taken_i) begin
                ctrl.if_id_flush     = 1'b1;
                ctrl.id_ex_flush     = 1'b1;
                ctrl.inhibit_control = 1'b1;
                flush_evt            = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_INIT;
                end else begin
                    state_d = RUN;
                end
            end else if (state_q == FLUSH) begin
                ctrl.if_id_flush     = 1'b1;
                ctrl.id_ex_flush     = 1'b1;
                ctrl.inhibit_control = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end else if (load_use) begin
                ctrl.pc_stall        = 1'b1;
                ctrl.if_id_stall     = 1'b1;
                ctrl.id_ex_flush     = 1'b1;
                ctrl.inhibit_control = 1'b1;
            end
        end

        timeout_d = timeout_q | (wait_d == WAIT_MAX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= BOOT;
            cnt_q     <= BUBBLE_INIT;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_stall_o        = ctrl.pc_stall;
    assign if_id_stall_o     = ctrl.if_id_stall;
    assign id_ex_stall_o     = ctrl.id_ex_stall;
    assign ex_mem_stall_o    = ctrl.ex_mem_stall;
    assign if_id_flush_o     = ctrl.if_id_flush;
    assign id_ex_flush_o     = ctrl.id_ex_flush;
    assign inhibit_control_o = ctrl.inhibit_control;
    assign mem_timeout_o     = timeout_q;

    perf_counter u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (ctrl.pc_stall),
        .count_o (stall_cycles_o)
    );

    perf_counter u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_evt),
        .count_o (flush_events_o)
    );

endmodule
